alu_issue: RTL

Sequential issue/control front end for the integer datapath. It accepts decoded-instruction requests (MIPS opcode/funct plus two operands) over a valid/ready handshake and maps them to the team's 3-bit ALU operation code and signedness. It executes one operation at a time, registers the result and overflow-trap status, and holds them on a valid/ready output until consumed. It sits between the decode stage and writeback/exception logic.

---
 rtl/alu_issue_pkg.sv | 63 ++++++
 rtl/alu_issue_decode.sv | 43 ++++
 rtl/alu_issue.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared ALU op codes, MIPS opcode/funct constants and issue types
package alu_issue_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        KIND_LOGIC   = 2'd0,
        KIND_ARITH   = 2'd1,
        KIND_CMP     = 2'd2,
        KIND_ILLEGAL = 2'd3
    } kind_e;

    typedef struct packed {
        logic [2:0] op;
        logic       unsig;
        kind_e      kind;
        logic       trap_en;
        logic       illegal;
    } dec_t;

    function automatic dec_t mk_dec(input logic [2:0] op, input logic unsig,
                                    input kind_e kind, input logic trap_en);
        dec_t d;
        d.op      = op;
        d.unsig   = unsig;
        d.kind    = kind;
        d.trap_en = trap_en;
        d.illegal = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational opcode/funct to ALU op, signedness, kind and trap decode
module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o.op      = ALU_AND;
        dec_o.unsig   = 1'b0;
        dec_o.kind    = KIND_ILLEGAL;
        dec_o.trap_en = 1'b0;
        dec_o.illegal = 1'b1;
        case (opcode_i)
            OPC_RTYPE: begin
                case (funct_i)
                    FN_ADD:  dec_o = mk_dec(ALU_ADD, 1'b0, KIND_ARITH, 1'b1);
                    FN_ADDU: dec_o = mk_dec(ALU_ADD, 1'b1, KIND_ARITH, 1'b0);
                    FN_SUB:  dec_o = mk_dec(ALU_SUB, 1'b0, KIND_ARITH, 1'b1);
                    FN_SUBU: dec_o = mk_dec(ALU_SUB, 1'b1, KIND_ARITH, 1'b0);
                    FN_AND:  dec_o = mk_dec(ALU_AND, 1'b0, KIND_LOGIC, 1'b0);
                    FN_OR:   dec_o = mk_dec(ALU_OR,  1'b0, KIND_LOGIC, 1'b0);
                    FN_XOR:  dec_o = mk_dec(ALU_XOR, 1'b0, KIND_LOGIC, 1'b0);
                    FN_NOR:  dec_o = mk_dec(ALU_NOR, 1'b0, KIND_LOGIC, 1'b0);
                    FN_SLT:  dec_o = mk_dec(ALU_SUB, 1'b0, KIND_CMP,   1'b0);
                    FN_SLTU: dec_o = mk_dec(ALU_SUB, 1'b1, KIND_CMP,   1'b0);
                    default: ;
                endcase
            end
            OPC_ADDI:  dec_o = mk_dec(ALU_ADD, 1'b0, KIND_ARITH, 1'b1);
            OPC_ADDIU: dec_o = mk_dec(ALU_ADD, 1'b1, KIND_ARITH, 1'b0);
            OPC_SLTI:  dec_o = mk_dec(ALU_SUB, 1'b0, KIND_CMP,   1'b0);
            OPC_SLTIU: dec_o = mk_dec(ALU_SUB, 1'b1, KIND_CMP,   1'b0);
            OPC_ANDI:  dec_o = mk_dec(ALU_AND, 1'b0, KIND_LOGIC, 1'b0);
            OPC_ORI:   dec_o = mk_dec(ALU_OR,  1'b0, KIND_LOGIC, 1'b0);
            OPC_XORI:  dec_o = mk_dec(ALU_XOR, 1'b0, KIND_LOGIC, 1'b0);
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - one-at-a-time issue FSM, ALU datapath, overflow trap and saturating counters
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int TRAP_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             ovf_trap,
    output logic             illegal,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] trap_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic             TRAP_ON = (TRAP_EN != 0);

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    dec_t             dec_q;
    logic [31:0]      result_q;
    logic             ovf_q;
    logic             illegal_q;
    logic [CNT_W-1:0] op_cnt_q;
    logic [CNT_W-1:0] trap_cnt_q;

    dec_t             dec_in;
    logic [31:0]      alu_r;
    logic [31:0]      result_d;
    logic             lt;
    logic             ovf_raw;
    logic             ovf_d;
    logic [CNT_W-1:0] op_cnt_d;
    logic [CNT_W-1:0] trap_cnt_d;

    alu_decode u_decode (
        .opcode_i (opcode),
        .funct_i  (funct),
        .dec_o    (dec_in)
    );

    // lt is a real magnitude compare so it stays correct when a-b overflows
    always_comb begin
        lt = dec_q.unsig ? (a_q < b_q) : ($signed(a_q) < $signed(b_q));
        case (dec_q.op)
            ALU_AND: alu_r = a_q & b_q;
            ALU_OR:  alu_r = a_q | b_q;
            ALU_ADD: alu_r = a_q + b_q;
            ALU_NOR: alu_r = ~(a_q | b_q);
            ALU_XOR: alu_r = a_q ^ b_q;
            ALU_SUB: alu_r = a_q - b_q;
            default: alu_r = 32'h0;
        endcase
        case (dec_q.kind)
            KIND_CMP:     result_d = {31'b0, lt};
            KIND_ILLEGAL: result_d = 32'h0;
            default:      result_d = alu_r;
        endcase
        ovf_raw = 1'b0;
        if (dec_q.op == ALU_ADD)
            ovf_raw = (a_q[31] == b_q[31]) && (alu_r[31] != a_q[31]);
        else if (dec_q.op == ALU_SUB)
            ovf_raw = (a_q[31] != b_q[31]) && (alu_r[31] != a_q[31]);
        ovf_d = TRAP_ON && dec_q.trap_en && (dec_q.kind == KIND_ARITH) && ovf_raw;
        op_cnt_d   = (&op_cnt_q)   ? op_cnt_q   : op_cnt_q + CNT_ONE;
        trap_cnt_d = (&trap_cnt_q) ? trap_cnt_q : trap_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            dec_q       <= '0;
            result_q    <= 32'h0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            op_cnt_q    <= '0;
            trap_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        dec_q      <= dec_in;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q    <= result_d;
                    ovf_q       <= ovf_d;
                    illegal_q   <= dec_q.illegal;
                    op_cnt_q    <= op_cnt_d;
                    if (ovf_d)
                        trap_cnt_q <= trap_cnt_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign ovf_trap   = ovf_q;
    assign illegal    = illegal_q;
    assign op_count   = op_cnt_q;
    assign trap_count = trap_cnt_q;

endmodule
